// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: a circular queue that accepts up
// to FETCH_WIDTH instructions per cycle and presents up to ISSUE_WIDTH to decode.
module inst_buffer #(
   parameter int DEPTH       = 8,
   parameter int FETCH_WIDTH = 2,
   parameter int ISSUE_WIDTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush_i,
   input  logic [FETCH_WIDTH-1:0]       fetch_valid_i,
   input  logic [FETCH_WIDTH*32-1:0]    fetch_pc_i,
   input  logic [FETCH_WIDTH*32-1:0]    fetch_inst_i,
   output logic                         fetch_ready_o,
   output logic [ISSUE_WIDTH-1:0]       issue_valid_o,
   output logic [ISSUE_WIDTH*32-1:0]    issue_pc_o,
   output logic [ISSUE_WIDTH*32-1:0]    issue_inst_o,
   input  logic [ISSUE_WIDTH-1:0]       issue_ack_i,
   output logic [$clog2(DEPTH):0]       count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] FW_C    = CW'(FETCH_WIDTH);

   logic [31:0]   pc_mem   [DEPTH];
   logic [31:0]   inst_mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [CW-1:0] push_n;
   logic [CW-1:0] pop_n;

   // Handshake: a lane/slot transfers at the rising edge when its valid is high,
   // the other side accepts it (fetch_ready_o / issue_ack_i), and every lower lane
   // or slot also transfers; fetch_ready_o depends only on registered occupancy.
   assign fetch_ready_o = (DEPTH_C - count) >= FW_C;
   assign count_o       = count;

   always_comb begin
      logic run;
      push_n = '0;
      run    = 1'b1;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (run && fetch_valid_i[i]) push_n = push_n + CW'(1);
         else                         run    = 1'b0;
      end
      if (!fetch_ready_o || flush_i) push_n = '0;
   end

   always_comb begin
      logic [PW-1:0] rd_idx;
      rd_idx        = '0;
      issue_valid_o = '0;
      issue_pc_o    = '0;
      issue_inst_o  = '0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         rd_idx = head + PW'(k);
         if (count > CW'(k)) begin
            issue_valid_o[k]       = 1'b1;
            issue_pc_o[32*k +: 32]   = pc_mem[rd_idx];
            issue_inst_o[32*k +: 32] = inst_mem[rd_idx];
         end
      end
   end

   always_comb begin
      logic run;
      pop_n = '0;
      run   = 1'b1;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         if (run && issue_ack_i[k] && issue_valid_o[k]) pop_n = pop_n + CW'(1);
         else                                            run   = 1'b0;
      end
      if (flush_i) pop_n = '0;
   end

   // Storage is not reset; only the pointers and occupancy define what is live.
   always_ff @(posedge clk) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (CW'(i) < push_n) begin
            pc_mem[tail + PW'(i)]   <= fetch_pc_i[32*i +: 32];
            inst_mem[tail + PW'(i)] <= fetch_inst_i[32*i +: 32];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + pop_n[PW-1:0];
         tail  <= tail + push_n[PW-1:0];
         count <= count + push_n - pop_n;
      end
   end

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer (DEPTH=8, FETCH_WIDTH=2, ISSUE_WIDTH=2)
// using a queue of {pc, inst} entries as the reference model.
module tb_inst_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush_i = 1'b0;
   logic [1:0]  fetch_valid_i = '0;
   logic [63:0] fetch_pc_i = '0;
   logic [63:0] fetch_inst_i = '0;
   logic        fetch_ready_o;
   logic [1:0]  issue_valid_o;
   logic [63:0] issue_pc_o;
   logic [63:0] issue_inst_o;
   logic [1:0]  issue_ack_i = '0;
   logic [3:0]  count_o;

   logic [63:0] exp_q[$];
   int vectors = 0;
   int miscompares = 0;

   inst_buffer #(.DEPTH(8), .FETCH_WIDTH(2), .ISSUE_WIDTH(2)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i), .fetch_inst_i(fetch_inst_i),
      .fetch_ready_o(fetch_ready_o),
      .issue_valid_o(issue_valid_o), .issue_pc_o(issue_pc_o), .issue_inst_o(issue_inst_o),
      .issue_ack_i(issue_ack_i), .count_o(count_o)
   );

   always #5 clk = ~clk;

   // One cycle: drive inputs, compare current outputs against the model, clock,
   // then retire pops and record pushes in the model.
   task automatic drive(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] pc1,
                        input logic [1:0] ack, input logic fl);
      logic [31:0] i0, i1, e_pc, e_inst;
      logic        e_v;
      int sz, pn, pp;
      i0 = $urandom;
      i1 = $urandom;
      fetch_valid_i = v;
      fetch_pc_i    = {pc1, pc0};
      fetch_inst_i  = {i1, i0};
      issue_ack_i   = ack;
      flush_i       = fl;
      #1;
      sz = exp_q.size();
      vectors++;
      if (count_o !== 4'(sz)) begin
         miscompares++;
         $display("FAIL sb_count: got %0d expected %0d", count_o, sz);
      end
      vectors++;
      if (fetch_ready_o !== (8 - sz >= 2)) begin
         miscompares++;
         $display("FAIL sb_ready: got %0b expected %0b", fetch_ready_o, (8 - sz >= 2));
      end
      for (int k = 0; k < 2; k++) begin
         e_v    = (k < sz);
         e_pc   = e_v ? exp_q[k][63:32] : 32'h0;
         e_inst = e_v ? exp_q[k][31:0]  : 32'h0;
         vectors++;
         if (issue_valid_o[k] !== e_v || issue_pc_o[32*k +: 32] !== e_pc ||
             issue_inst_o[32*k +: 32] !== e_inst) begin
            miscompares++;
            $display("FAIL sb_slot%0d: got v=%0b pc=%h inst=%h expected v=%0b pc=%h inst=%h",
                     k, issue_valid_o[k], issue_pc_o[32*k +: 32], issue_inst_o[32*k +: 32],
                     e_v, e_pc, e_inst);
         end
      end
      pn = 0;
      if (sz <= 6 && !fl && v[0]) pn = v[1] ? 2 : 1;
      pp = 0;
      if (!fl && ack[0] && sz > 0) pp = (ack[1] && sz > 1) ? 2 : 1;
      @(posedge clk);
      #1;
      if (fl) exp_q.delete();
      else begin
         repeat (pp) void'(exp_q.pop_front());
         if (pn > 0) exp_q.push_back({pc0, i0});
         if (pn > 1) exp_q.push_back({pc1, i1});
      end
      fetch_valid_i = '0;
      issue_ack_i   = '0;
      flush_i       = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #1;
      vectors++;
      if (count_o !== 4'd0 || issue_valid_o !== 2'b00 || fetch_ready_o !== 1'b1 ||
          issue_pc_o !== 64'h0 || issue_inst_o !== 64'h0) begin
         miscompares++;
         $display("FAIL reset: got count=%0d valid=%b ready=%b pc=%h expected 0/00/1/0",
                  count_o, issue_valid_o, fetch_ready_o, issue_pc_o);
      end
      do_reset();
   endtask

   task automatic test_basic_push();
      do_reset();
      drive(2'b11, 32'h1c000000, 32'h1c000004, 2'b00, 1'b0);
      vectors++;
      if (count_o !== 4'd2 || issue_valid_o !== 2'b11 ||
          issue_pc_o !== {32'h1c000004, 32'h1c000000}) begin
         miscompares++;
         $display("FAIL basic_push: got count=%0d valid=%b pc=%h expected 2/11/1c0000041c000000",
                  count_o, issue_valid_o, issue_pc_o);
      end
      drive(2'b00, 0, 0, 2'b00, 1'b0);
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 4; i++) drive(2'b11, 32'h100 + 8*i, 32'h104 + 8*i, 2'b00, 1'b0);
      vectors++;
      if (count_o !== 4'd8 || fetch_ready_o !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_full: got count=%0d ready=%b expected 8/0", count_o, fetch_ready_o);
      end
      drive(2'b11, 32'hbad0, 32'hbad4, 2'b00, 1'b0);
      vectors++;
      if (count_o !== 4'd8) begin
         miscompares++;
         $display("FAIL fill_overflow: got count=%0d expected 8", count_o);
      end
      drive(2'b00, 0, 0, 2'b01, 1'b0);
      vectors++;
      if (count_o !== 4'd7 || fetch_ready_o !== 1'b0) begin
         miscompares++;
         $display("FAIL fill_ack1: got count=%0d ready=%b expected 7/0", count_o, fetch_ready_o);
      end
      drive(2'b00, 0, 0, 2'b01, 1'b0);
      vectors++;
      if (count_o !== 4'd6 || fetch_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL fill_ack2: got count=%0d ready=%b expected 6/1", count_o, fetch_ready_o);
      end
      for (int i = 0; i < 3; i++) drive(2'b00, 0, 0, 2'b11, 1'b0);
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 4; i++) drive(2'b11, 32'h200 + 8*i, 32'h204 + 8*i, 2'b00, 1'b0);
      for (int i = 0; i < 3; i++) drive(2'b00, 0, 0, 2'b11, 1'b0);
      drive(2'b11, 32'h3000, 32'h3004, 2'b11, 1'b0);
      vectors++;
      if (count_o !== 4'd2 || issue_pc_o[31:0] !== 32'h3000 || issue_pc_o[63:32] !== 32'h3004) begin
         miscompares++;
         $display("FAIL wrap: got count=%0d pc=%h expected 2/0000300400003000", count_o, issue_pc_o);
      end
      drive(2'b11, 32'h3008, 32'h300c, 2'b01, 1'b0);
   endtask

   task automatic test_gapped();
      do_reset();
      drive(2'b11, 32'h400, 32'h404, 2'b00, 1'b0);
      drive(2'b10, 32'h408, 32'h40c, 2'b00, 1'b0);
      vectors++;
      if (count_o !== 4'd2) begin
         miscompares++;
         $display("FAIL gapped_push: got count=%0d expected 2", count_o);
      end
      drive(2'b00, 0, 0, 2'b10, 1'b0);
      vectors++;
      if (count_o !== 4'd2 || issue_pc_o[31:0] !== 32'h400) begin
         miscompares++;
         $display("FAIL gapped_ack: got count=%0d pc0=%h expected 2/400", count_o, issue_pc_o[31:0]);
      end
      drive(2'b00, 0, 0, 2'b00, 1'b0);
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 3; i++) drive(2'b11, 32'h500 + 8*i, 32'h504 + 8*i, 2'b00, 1'b0);
      drive(2'b00, 0, 0, 2'b01, 1'b0);
      drive(2'b11, 32'h600, 32'h604, 2'b11, 1'b1);
      vectors++;
      if (count_o !== 4'd0 || issue_valid_o !== 2'b00 || issue_pc_o !== 64'h0 ||
          issue_inst_o !== 64'h0 || fetch_ready_o !== 1'b1) begin
         miscompares++;
         $display("FAIL flush: got count=%0d valid=%b pc=%h ready=%b expected 0/00/0/1",
                  count_o, issue_valid_o, issue_pc_o, fetch_ready_o);
      end
      drive(2'b00, 0, 0, 2'b00, 1'b0);
   endtask

   task automatic test_rst_mid();
      do_reset();
      drive(2'b11, 32'h700, 32'h704, 2'b00, 1'b0);
      drive(2'b01, 32'h708, 32'h70c, 2'b00, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (issue_valid_o !== 2'b00 || count_o !== 4'd0) begin
         miscompares++;
         $display("FAIL rst_mid: got valid=%b count=%0d expected 00/0", issue_valid_o, count_o);
      end
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(2'b00, 0, 0, 2'b00, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] base;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         base = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
         drive(2'($urandom_range(0, 3)), base, base + 32'd4, 2'($urandom_range(0, 3)),
               ($urandom_range(0, 19) == 0));
      end
   endtask

   initial begin
      test_reset();
      test_basic_push();
      test_fill();
      test_wrap();
      test_gapped();
      test_flush();
      test_rst_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/inst_buffer.md
INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 Parameter DEPTH, default 8, queue entries; power of two, minimum 4.
REQ-002 Parameter FETCH_WIDTH, default 2, instructions offered per cycle by fetch; 1..DEPTH/2.
REQ-003 Parameter ISSUE_WIDTH, default 2, instructions presented per cycle to decode; 1..DEPTH.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset; asynchronous, active-high.
REQ-006 Port flush_i  input  1  branch/exception redirect; discards all queued instructions.
REQ-007 Port fetch_valid_i  input  FETCH_WIDTH  per-lane valid from fetch; lane 0 oldest.
REQ-008 Port fetch_pc_i  input  FETCH_WIDTH*32  per-lane PC; lane i at bits [32i+31:32i].
REQ-009 Port fetch_inst_i  input  FETCH_WIDTH*32  per-lane instruction word, same packing.
REQ-010 Port fetch_ready_o  output  1  buffer accepts a full fetch group this cycle.
REQ-011 Port issue_valid_o  output  ISSUE_WIDTH  per-slot valid to decode; slot 0 oldest.
REQ-012 Port issue_pc_o  output  ISSUE_WIDTH*32  per-slot PC, same packing.
REQ-013 Port issue_inst_o  output  ISSUE_WIDTH*32  per-slot instruction word, same packing.
REQ-014 Port issue_ack_i  input  ISSUE_WIDTH  per-slot consume from decode.
REQ-015 Port count_o  output  $clog2(DEPTH)+1  current occupancy, for debug/perf counters.

Function
REQ-016 Storage SHALL be a circular queue of DEPTH {pc, inst} entries with head, tail pointers and occupancy count; pointers wrap modulo DEPTH.
REQ-017 fetch_ready_o SHALL be 1 iff DEPTH - count >= FETCH_WIDTH, using current-cycle count (pops in the same cycle not credited).
REQ-018 Push count SHALL be the number of leading consecutive ones of fetch_valid_i from lane 0, forced to 0 when fetch_ready_o=0 or flush_i=1; lanes after the first 0 are dropped.
REQ-019 Pushed lanes SHALL be written in lane order at tail, tail+1, ...; tail advances by push count at the clock edge.
REQ-020 Slot k outputs SHALL show entry head+k (mod DEPTH) when count > k, combinationally from storage; otherwise issue_valid_o[k]=0 and issue_pc_o/issue_inst_o slot k = 0.
REQ-021 Pop count SHALL be the number of leading consecutive ones of (issue_ack_i & issue_valid_o) from slot 0, forced to 0 when flush_i=1; ack on an invalid slot or after a gap is ignored.
REQ-022 head SHALL advance by pop count; count next = count + push - pop; push and pop in the same cycle are both honoured, including when count=0 (no bypass: entries pushed this cycle are first visible next cycle).
REQ-023 Full (count=DEPTH) SHALL never be exceeded; empty SHALL present all slots invalid and zero.
REQ-024 flush_i=1 SHALL, at that edge, set head=tail=0, count=0, discarding same-cycle push and pop; outputs are invalid/zero the following cycle.
REQ-025 Issue outputs and fetch_ready_o SHALL be free of combinational paths from issue_ack_i and fetch_valid_i.

Reset
REQ-026 rst=1 SHALL immediately, independent of clk, set head=tail=0, count=0; hence issue_valid_o=0, issue outputs 0, count_o=0, fetch_ready_o=1.
REQ-027 rst asserted mid-operation SHALL discard all entries; storage array contents need not be reset.
REQ-028 rst has priority over flush_i and all push/pop activity.

Verification (DEPTH=8, FETCH_WIDTH=2, ISSUE_WIDTH=2)
REQ-029 Reset then push valid=11 pc 0x1c000000/0x1c000004, ack=00 -> next cycle count_o=2, slots valid=11 with those PCs in order.
REQ-030 Fill: four pushes of valid=11, no ack -> count_o=8, fetch_ready_o=0; fifth push ignored, count_o stays 8; one ack=01 -> count_o=7, fetch_ready_o still 0; second ack=01 -> count_o=6, fetch_ready_o=1.
REQ-031 Wrap: with head=6, count=2, push valid=11 and ack=11 same cycle -> count_o=2, tail wraps to 2, slot 0 shows first new PC next cycle.
REQ-032 Gapped lanes: push valid=10 -> nothing written; ack=10 with count=2 -> nothing popped, count unchanged.
REQ-033 Flush with count=5 plus simultaneous push valid=11 and ack=11 -> next cycle count_o=0, valid=00, outputs 0, fetch_ready_o=1.
REQ-034 rst pulse between clock edges with count=3 -> issue_valid_o=00 and count_o=0 before the next rising edge.
